// File: rtl/set_input_pkg.sv
// Shared types, constants and helpers for the set_input time/alarm editor.
// Optional build macro: SET_INPUT_DEBOUNCE_EN (see btn_cond).
package set_input_pkg;

    typedef logic [16:0] COUNTER_T;
    typedef logic        FLAG_T;
    typedef logic [5:0]  TIME_T;

    localparam COUNTER_T COUNTER_MAX = 17'd86399;
    localparam COUNTER_T MIN_TICK    = 17'd60;
    localparam COUNTER_T HOUR_TICK   = 17'd3600;

    localparam TIME_T HOUR_MAX = 6'd23;
    localparam TIME_T MIN_MAX  = 6'd59;
    localparam TIME_T SEC_MAX  = 6'd59;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    typedef enum logic [2:0] {IDLE, LOAD, HOUR, MIN, SEC} state_t;
    typedef enum logic {TGT_TIME, TGT_ALARM} target_t;

    function automatic COUNTER_T compose(TIME_T h, TIME_T m, TIME_T s);
        return COUNTER_T'(h) * HOUR_TICK
             + COUNTER_T'(m) * MIN_TICK
             + COUNTER_T'(s);
    endfunction

    // Wrapping step of one field; no carry into neighbours.
    function automatic TIME_T step(TIME_T v, TIME_T max, logic up);
        if (up)
            return (v >= max) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? max : v - 6'd1;
    endfunction

endpackage

// File: rtl/set_input_if.sv
// Button, timestamp and setpoint bundle between a controller and set_input.
// Optional build macro: SET_INPUT_DEBOUNCE_EN (no effect on this bundle).
import set_input_pkg::*;

interface set_input_if;
    logic     btn_set;
    logic     btn_alarm_set;
    logic     btn_alarm_toggle;
    logic     btn_inc;
    logic     btn_dec;
    logic     btn_next;
    logic     btn_cancel;
    COUNTER_T counter_state;
    FLAG_T    set_flag;
    COUNTER_T set_time;
    FLAG_T    alarm_flag;
    COUNTER_T alarm_time;
    logic [1:0] edit_field;
    logic     busy;

    modport master (
        output btn_set, btn_alarm_set, btn_alarm_toggle,
        output btn_inc, btn_dec, btn_next, btn_cancel,
        output counter_state,
        input  set_flag, set_time, alarm_flag, alarm_time,
        input  edit_field, busy
    );

    modport slave (
        input  btn_set, btn_alarm_set, btn_alarm_toggle,
        input  btn_inc, btn_dec, btn_next, btn_cancel,
        input  counter_state,
        output set_flag, set_time, alarm_flag, alarm_time,
        output edit_field, busy
    );
endinterface

// File: rtl/set_input_btn_cond.sv
// Raw button -> one-cycle press pulse (sync, optional debounce, edge detect).
// Optional build macro: SET_INPUT_DEBOUNCE_EN enables the stability filter.
module btn_cond #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);

    if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
        $error("btn_cond: DEBOUNCE_CYCLES must be at least 1");
    end

    logic s1, s2, lvl, lvl_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl_q <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            lvl_q <= lvl;
        end
    end

`ifdef SET_INPUT_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt;

    // Accept a new level only after it has held for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            lvl <= 1'b0;
        end else if (s2 == lvl) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt <= '0;
            lvl <= s2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign lvl = s2;
`endif

    assign press = lvl & ~lvl_q;

endmodule

// File: rtl/set_input.sv
// Time / alarm setpoint editor: capture, split into h/m/s, edit, commit.
// Optional build macro: SET_INPUT_DEBOUNCE_EN adds button debounce.
import set_input_pkg::*;

module set_input #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    set_input_if.slave  bus
);

    localparam int P_SET    = 0;
    localparam int P_ASET   = 1;
    localparam int P_TOG    = 2;
    localparam int P_INC    = 3;
    localparam int P_DEC    = 4;
    localparam int P_NEXT   = 5;
    localparam int P_CANCEL = 6;

    logic [6:0] raw, press;

    assign raw = {bus.btn_cancel, bus.btn_next, bus.btn_dec,
                  bus.btn_inc, bus.btn_alarm_toggle,
                  bus.btn_alarm_set, bus.btn_set};

    for (genvar i = 0; i < 7; i++) begin : g_btn
        btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clock (clock),
            .reset (reset),
            .raw   (raw[i]),
            .press (press[i])
        );
    end

    state_t     state;
    target_t    target;
    COUNTER_T   cap, rem, nrem, cap_in, composed;
    TIME_T      hr, mn, sc, nhr, nmn;
    FLAG_T      saved_flag;
    FLAG_T      set_flag_r, alarm_flag_r;
    COUNTER_T   set_time_r, alarm_time_r;
    logic [1:0] edit_field_r;
    logic       busy_r;

    assign cap_in = (bus.counter_state > COUNTER_MAX) ?
                    COUNTER_MAX : bus.counter_state;
    assign composed = compose(hr, mn, sc);

    // One subtraction per LOAD cycle: hours first, then minutes.
    always_comb begin
        nrem = rem;
        nhr  = hr;
        nmn  = mn;
        if (rem >= HOUR_TICK) begin
            nrem = rem - HOUR_TICK;
            nhr  = hr + 6'd1;
        end else if (rem >= MIN_TICK) begin
            nrem = rem - MIN_TICK;
            nmn  = mn + 6'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            target       <= TGT_TIME;
            cap          <= '0;
            rem          <= '0;
            hr           <= '0;
            mn           <= '0;
            sc           <= '0;
            saved_flag   <= 1'b0;
            set_flag_r   <= 1'b0;
            set_time_r   <= '0;
            alarm_flag_r <= 1'b0;
            alarm_time_r <= '0;
            edit_field_r <= FIELD_NONE;
            busy_r       <= 1'b0;
        end else begin
            if (target == TGT_TIME && busy_r && state != LOAD)
                set_time_r <= composed;
            unique case (state)
                IDLE: begin
                    if (press[P_SET]) begin
                        cap    <= cap_in;
                        rem    <= cap_in;
                        target <= TGT_TIME;
                        hr     <= '0;
                        mn     <= '0;
                        sc     <= '0;
                        busy_r <= 1'b1;
                        state  <= LOAD;
                    end else if (press[P_ASET]) begin
                        cap          <= alarm_time_r;
                        rem          <= alarm_time_r;
                        target       <= TGT_ALARM;
                        saved_flag   <= alarm_flag_r;
                        alarm_flag_r <= 1'b0;
                        hr           <= '0;
                        mn           <= '0;
                        sc           <= '0;
                        busy_r       <= 1'b1;
                        state        <= LOAD;
                    end else if (press[P_TOG]) begin
                        alarm_flag_r <= ~alarm_flag_r;
                    end
                end
                LOAD: begin
                    rem <= nrem;
                    hr  <= nhr;
                    mn  <= nmn;
                    if (nrem < MIN_TICK) begin
                        sc           <= nrem[5:0];
                        edit_field_r <= FIELD_HOUR;
                        state        <= HOUR;
                        if (target == TGT_TIME) begin
                            set_flag_r <= 1'b1;
                            set_time_r <= cap;
                        end
                    end
                end
                HOUR, MIN, SEC: begin
                    if (press[P_CANCEL]) begin
                        state        <= IDLE;
                        busy_r       <= 1'b0;
                        edit_field_r <= FIELD_NONE;
                        if (target == TGT_TIME) begin
                            set_time_r <= cap;
                            set_flag_r <= 1'b0;
                        end else begin
                            alarm_flag_r <= saved_flag;
                        end
                    end else if (press[P_NEXT]) begin
                        if (state == HOUR) begin
                            state        <= MIN;
                            edit_field_r <= FIELD_MIN;
                        end else if (state == MIN) begin
                            state        <= SEC;
                            edit_field_r <= FIELD_SEC;
                        end else begin
                            state        <= IDLE;
                            busy_r       <= 1'b0;
                            edit_field_r <= FIELD_NONE;
                            if (target == TGT_TIME) begin
                                set_flag_r <= 1'b0;
                                set_time_r <= composed;
                            end else begin
                                alarm_time_r <= composed;
                                alarm_flag_r <= 1'b1;
                            end
                        end
                    end else if (press[P_INC] || press[P_DEC]) begin
                        if (state == HOUR)
                            hr <= step(hr, HOUR_MAX, press[P_INC]);
                        else if (state == MIN)
                            mn <= step(mn, MIN_MAX, press[P_INC]);
                        else
                            sc <= step(sc, SEC_MAX, press[P_INC]);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.set_flag   = set_flag_r;
    assign bus.set_time   = set_time_r;
    assign bus.alarm_flag = alarm_flag_r;
    assign bus.alarm_time = alarm_time_r;
    assign bus.edit_field = edit_field_r;
    assign bus.busy       = busy_r;

endmodule
